mem_arbiter: RTL and testbench

Arbiter that shares the single physical-memory port between the instruction-fetch side and the data-memory side of the pipelined LC-3b core. It sits between the fetch stage's instruction cache and the MEM stage's data cache on one side and physical memory on the other. It serialises line-sized transactions, one at a time. It returns each response only to the side that owns the transaction, so the fetch-stage advance/stall logic sees `i_resp` only for its own fills.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 96 +++++++++
 tb/tb_mem_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Shared-memory-port bundle: instruction side, data side and physical memory.
// The arbiter uses the slave view; the surrounding caches and memory use master.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  modport slave (
    input  i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    output i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_read, i_address, d_read, d_write, d_address, d_wdata,
           pmem_rdata, pmem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp,
           pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serialises I-cache and D-cache line transactions onto one physical-memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the data side always wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [ADDR_W-1:0] addr_reg;
  logic [LINE_W-1:0] wdata_reg;
  logic [LINE_W-1:0] i_line_reg;
  logic [LINE_W-1:0] d_line_reg;
  logic              write_reg;
  logic              owner_d_reg;
  logic              d_req;
  logic              i_req;
  logic              grant_d;
  logic              busy;

`ifdef MEM_ARB_RR_EN
  logic              last_d_reg;
`endif

  // Arbitration decision, only consulted while IDLE.
  always_comb begin
    d_req = bus.d_read | bus.d_write;
    i_req = bus.i_read;
`ifdef MEM_ARB_RR_EN
    grant_d = d_req && (!i_req || !last_d_reg);
`else
    grant_d = d_req;
`endif
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:           if (d_req || i_req) state_next = grant_d ? BUSY_D : BUSY_I;
      BUSY_I, BUSY_D: if (bus.pmem_resp) state_next = DONE;
      DONE:           state_next = IDLE;
      default:        state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      wdata_reg   <= '0;
      write_reg   <= 1'b0;
      owner_d_reg <= 1'b0;
      i_line_reg  <= '0;
      d_line_reg  <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      // Latch the winner once; later address/data changes are ignored.
      if (state_reg == IDLE && (d_req || i_req)) begin
        addr_reg    <= grant_d ? bus.d_address : bus.i_address;
        wdata_reg   <= grant_d ? bus.d_wdata : '0;
        write_reg   <= grant_d & bus.d_write;
        owner_d_reg <= grant_d;
      end
      if ((state_reg == BUSY_I || state_reg == BUSY_D) && bus.pmem_resp) begin
        if (owner_d_reg) d_line_reg <= bus.pmem_rdata;
        else             i_line_reg <= bus.pmem_rdata;
      end
`ifdef MEM_ARB_RR_EN
      if (state_reg == DONE) last_d_reg <= owner_d_reg;
`endif
    end
  end

  // Outputs decode registers only, so no input reaches an output combinationally.
  always_comb begin
    busy             = (state_reg == BUSY_I) || (state_reg == BUSY_D);
    bus.pmem_read    = busy && !write_reg;
    bus.pmem_write   = busy && write_reg;
    bus.pmem_address = addr_reg;
    bus.pmem_wdata   = wdata_reg;
    bus.i_resp       = (state_reg == DONE) && !owner_d_reg;
    bus.d_resp       = (state_reg == DONE) && owner_d_reg;
    bus.i_rdata      = i_line_reg;
    bus.d_rdata      = d_line_reg;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; grant order expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;
  logic last_d_tb = 1'b0;
  logic g;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected winner of an IDLE-cycle arbitration.
  function automatic logic exp_grant_d(input logic d_req, input logic i_req);
    logic rr;
`ifdef MEM_ARB_RR_EN
    rr = 1'b1;
`else
    rr = 1'b0;
`endif
    return d_req && (!rr || !i_req || !last_d_tb);
  endfunction

  task automatic idle(input string tag);
    tick();
    chk({tag, ".i_resp"}, bus.i_resp, 1'b0);
    chk({tag, ".d_resp"}, bus.d_resp, 1'b0);
    chk({tag, ".pmem_read"}, bus.pmem_read, 1'b0);
    chk({tag, ".pmem_write"}, bus.pmem_write, 1'b0);
  endtask

  // Grant edge, lat command cycles (pmem_resp in the last), then the DONE cycle.
  task automatic txn(input string tag, input logic exp_d, input logic exp_w,
                     input logic [ADDR_W-1:0] exp_addr, input logic [LINE_W-1:0] exp_wdata,
                     input int lat, input logic [LINE_W-1:0] line, input logic drop);
    tick();
    for (int c = 0; c < lat; c++) begin
      chk($sformatf("%s.c%0d.pmem_read", tag, c), bus.pmem_read, !exp_w);
      chk($sformatf("%s.c%0d.pmem_write", tag, c), bus.pmem_write, exp_w);
      chk($sformatf("%s.c%0d.pmem_address", tag, c), bus.pmem_address, exp_addr);
      if (exp_w) chk($sformatf("%s.c%0d.pmem_wdata", tag, c), bus.pmem_wdata, exp_wdata);
      chk($sformatf("%s.c%0d.resp", tag, c), {bus.i_resp, bus.d_resp}, 2'b00);
      if (c == 0 && drop) begin
        bus.i_read = 1'b0;
        bus.d_read = 1'b0;
        bus.d_write = 1'b0;
      end
      // Disturb the request-side inputs: the latched copy must not change.
      bus.i_address = ~exp_addr;
      bus.d_address = ~exp_addr;
      if (c == lat - 1) begin
        bus.pmem_resp = 1'b1;
        bus.pmem_rdata = line;
      end
      tick();
    end
    bus.pmem_resp = 1'b0;
    bus.pmem_rdata = ~line;
    chk({tag, ".i_resp"}, bus.i_resp, !exp_d);
    chk({tag, ".d_resp"}, bus.d_resp, exp_d);
    chk({tag, ".done_cmd"}, {bus.pmem_read, bus.pmem_write}, 2'b00);
    if (!exp_w) chk({tag, ".rdata"}, exp_d ? bus.d_rdata : bus.i_rdata, line);
    last_d_tb = exp_d;
  endtask

  task automatic serve(input string tag, input logic gd, input logic [ADDR_W-1:0] ia,
                       input logic [ADDR_W-1:0] da, input int lat, input logic [LINE_W-1:0] line);
    bus.i_address = ia;
    bus.d_address = da;
    txn(tag, gd, gd & bus.d_write, gd ? da : ia, bus.d_wdata, lat, line, 1'b0);
  endtask

  initial begin
    bus.i_read = 0; bus.i_address = '0; bus.d_read = 0; bus.d_write = 0;
    bus.d_address = '0; bus.d_wdata = '0; bus.pmem_rdata = '0; bus.pmem_resp = 0;

    // Reset values
    bus.pmem_resp = 1'b1;
    tick(); tick();
    chk("rst.pmem_read", bus.pmem_read, 1'b0);
    chk("rst.pmem_write", bus.pmem_write, 1'b0);
    chk("rst.pmem_address", bus.pmem_address, '0);
    chk("rst.pmem_wdata", bus.pmem_wdata, '0);
    chk("rst.resp", {bus.i_resp, bus.d_resp}, 2'b00);
    chk("rst.i_rdata", bus.i_rdata, '0);
    chk("rst.d_rdata", bus.d_rdata, '0);
    bus.pmem_resp = 1'b0;
    rst_n = 1'b1;
    last_d_tb = 1'b0;
    idle("post_rst_idle");

    // Single I read, 3-cycle memory latency
    bus.i_read = 1'b1;
    serve("i_rd", 1'b0, 16'h1230, 16'h0000, 3, 128'hA5A5_0001_1111_2222_3333_4444_5555_6666);
    bus.i_read = 1'b0;
    idle("i_rd.after");

    // Single D write
    bus.d_write = 1'b1;
    bus.d_wdata = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
    serve("d_wr", 1'b1, 16'h0000, 16'h8000, 2, 128'h0);
    bus.d_write = 1'b0;
    idle("d_wr.after");

    // Simultaneous I and D, both held until served
    bus.i_read = 1'b1;
    bus.d_read = 1'b1;
    g = exp_grant_d(1'b1, 1'b1);
    serve("tie.first", g, 16'h2000, 16'h4000, 2, 128'h1111_0000_0000_0000_0000_0000_0000_00AA);
    if (g) bus.d_read = 1'b0; else bus.i_read = 1'b0;
    idle("tie.gap");
    g = exp_grant_d(bus.d_read, bus.i_read);
    serve("tie.second", g, 16'h2000, 16'h4000, 2, 128'h2222_0000_0000_0000_0000_0000_0000_00BB);
    bus.i_read = 1'b0;
    bus.d_read = 1'b0;
    idle("tie.after");

    // Back-to-back D re-raises with I pending throughout
    bus.i_read = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus.d_read = 1'b1;
      g = exp_grant_d(1'b1, 1'b1);
      serve($sformatf("b2b%0d", r), g, 16'h2100, 16'h4100 + 16'(r * 16), 1,
            128'h3000 + 128'(r));
      if (g) bus.d_read = 1'b0;
      idle($sformatf("b2b%0d.gap", r));
    end
    bus.d_read = 1'b0;
    serve("b2b.i_last", 1'b0, 16'h2100, 16'h0000, 1, 128'h3333_4444);
    bus.i_read = 1'b0;
    idle("b2b.after");

    // I request dropped one cycle after grant still completes once
    bus.i_read = 1'b1;
    bus.i_address = 16'h3330;
    txn("drop", 1'b0, 1'b0, 16'h3330, '0, 3, 128'h5555_6666_7777_8888_9999_AAAA_BBBB_CCCC, 1'b1);
    idle("drop.idle1");
    idle("drop.idle2");

    // Stray pmem_resp while idle
    bus.pmem_resp = 1'b1;
    idle("stray1");
    bus.pmem_resp = 1'b0;
    idle("stray2");

    // Reset in the middle of a D write
    bus.d_write = 1'b1;
    bus.d_address = 16'h8040;
    bus.d_wdata = 128'h0BAD_F00D;
    tick();
    chk("rst_mid.pmem_write", bus.pmem_write, 1'b1);
    tick();
    rst_n = 1'b0;
    bus.d_write = 1'b0;
    tick();
    rst_n = 1'b1;
    last_d_tb = 1'b0;
    chk("rst_mid.pmem_write_drop", bus.pmem_write, 1'b0);
    chk("rst_mid.pmem_address", bus.pmem_address, '0);
    chk("rst_mid.d_resp", bus.d_resp, 1'b0);
    idle("rst_mid.idle");
    bus.d_write = 1'b1;
    serve("rst_mid.retry", exp_grant_d(1'b1, 1'b0), 16'h0000, 16'h8040, 2, 128'h0);
    bus.d_write = 1'b0;
    idle("rst_mid.after");

    // Read line registers hold between responses (last I line came from the reset-cleared state)
    chk("hold.i_rdata", bus.i_rdata, '0);
    bus.i_read = 1'b1;
    serve("hold.i_rd", 1'b0, 16'h0440, 16'h0000, 1, 128'h7777_1234);
    bus.i_read = 1'b0;
    idle("hold.gap");
    bus.d_write = 1'b1;
    serve("hold.d_wr", 1'b1, 16'h0000, 16'h9000, 1, 128'h0);
    bus.d_write = 1'b0;
    idle("hold.after");
    chk("hold.i_rdata2", bus.i_rdata, 128'h7777_1234);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
